// File: rtl/mux_scan_sequencer_if.sv
// Handshake and muxN-side signal bundle for mux_scan_sequencer.
// slave = the sequencer; master = upstream source plus muxN.
interface mux_scan_sequencer_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [N-1:0]  mux_x;
    logic [SW-1:0] mux_sel;
    logic          mux_y;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_last;
    logic          busy;

    modport slave (
        input  in_valid, in_data, mux_y,
        output in_ready, mux_x, mux_sel, bit_out, bit_valid, bit_last, busy
    );

    modport master (
        output in_valid, in_data, mux_y,
        input  in_ready, mux_x, mux_sel, bit_out, bit_valid, bit_last, busy
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Parallel-to-serial scanner driving muxN select/data and registering its output.
// Define MUX_SCAN_PARITY_EN to append an even-parity bit after bit N-1.
module mux_scan_sequencer #(
    parameter int N    = 8,
    parameter int HOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_sequencer_if.slave   bus
);
    localparam int SW = $clog2(N);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [SW-1:0] SEL_LAST  = SW'(N - 1);

`ifdef MUX_SCAN_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SCAN} state_t;
`endif

    state_t        state_q, state_d;
    logic [N-1:0]  mux_x_q, mux_x_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          bit_out_q, bit_out_d;
    logic          bit_valid_q, bit_valid_d;
    logic          bit_last_q, bit_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mux_x_q     <= '0;
            sel_q       <= '0;
            hold_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_x_q     <= mux_x_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_last_q  <= bit_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mux_x_d     = mux_x_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        bit_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mux_x_d = bus.in_data;
                    sel_d   = '0;
                    hold_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d      = '0;
                    bit_out_d   = bus.mux_y;
                    bit_valid_d = 1'b1;
                    // select parks at N-1 once the word is exhausted
                    if (sel_q == SEL_LAST) begin
`ifdef MUX_SCAN_PARITY_EN
                        state_d    = S_PAR;
`else
                        bit_last_d = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
`ifdef MUX_SCAN_PARITY_EN
            S_PAR: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d      = '0;
                    bit_out_d   = ^mux_x_q;
                    bit_valid_d = 1'b1;
                    bit_last_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is forced low while reset is held so every output reads 0 in reset
    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mux_x     = mux_x_q;
    assign bus.mux_sel   = sel_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_last  = bit_last_q;
endmodule
